// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths and
// the canonical field layout of the bundle carried from EX to MEM.
package ex_mem_pkg;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned REG_AW_DEFAULT = 5;

    // Field order here is the packing order used by the register itself.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0]   alu_result;
        logic [XLEN_DEFAULT-1:0]   rs2_data;
        logic [REG_AW_DEFAULT-1:0] rd;
        logic                      reg_write;
        logic                      mem_write;
        logic                      mem_read;
        logic                      branch_taken;
    } ex_mem_bundle_t;

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// EX -> MEM bus: EX-stage inputs and the registered copies seen by MEM.
interface ex_mem_pipe_reg_if
    import ex_mem_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned REG_AW = REG_AW_DEFAULT
);
    logic [XLEN-1:0]   alu_result_in;
    logic [XLEN-1:0]   rs2_data_in;
    logic [REG_AW-1:0] rd_in;
    logic              reg_write_in;
    logic              mem_write_in;
    logic              mem_read_in;
    logic              branch_taken_in;

    logic [XLEN-1:0]   alu_result_out;
    logic [XLEN-1:0]   rs2_data_out;
    logic [REG_AW-1:0] rd_out;
    logic              reg_write_out;
    logic              mem_write_out;
    logic              mem_read_out;
    logic              branch_taken_out;
    logic              valid_out;
    logic              mem_access_out;
    logic              fwd_en_out;

    // EX-stage side: drives the inputs, observes the registered outputs.
    modport master (
        output alu_result_in, rs2_data_in, rd_in,
               reg_write_in, mem_write_in, mem_read_in, branch_taken_in,
        input  alu_result_out, rs2_data_out, rd_out,
               reg_write_out, mem_write_out, mem_read_out, branch_taken_out,
               valid_out, mem_access_out, fwd_en_out
    );

    // Pipeline register side.
    modport slave (
        input  alu_result_in, rs2_data_in, rd_in,
               reg_write_in, mem_write_in, mem_read_in, branch_taken_in,
        output alu_result_out, rs2_data_out, rd_out,
               reg_write_out, mem_write_out, mem_read_out, branch_taken_out,
               valid_out, mem_access_out, fwd_en_out
    );

endinterface

// File: rtl/ex_mem_pipe_reg_dff.sv
// Width-parameterised D flop with synchronous active-high reset to zero.
module pipe_dff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture on every rising edge; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: one-cycle copy of the EX-stage bundle plus a
// valid flag, with memory-access and forwarding hints decoded from the
// registered values only.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    ex_mem_pipe_reg_if.slave bus
);

    // Same layout as ex_mem_bundle_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   rs2_data;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic              branch_taken;
    } bundle_t;

    bundle_t d_bundle;
    bundle_t q_bundle;
    logic    valid_q;

    assign d_bundle = '{
        alu_result:   bus.alu_result_in,
        rs2_data:     bus.rs2_data_in,
        rd:           bus.rd_in,
        reg_write:    bus.reg_write_in,
        mem_write:    bus.mem_write_in,
        mem_read:     bus.mem_read_in,
        branch_taken: bus.branch_taken_in
    };

    pipe_dff #(.WIDTH($bits(bundle_t))) u_data (
        .clk (clk),
        .rst (rst),
        .d   (d_bundle),
        .q   (q_bundle)
    );

    // Valid rises on the first edge after reset release and stays high.
    pipe_dff #(.WIDTH(1)) u_valid (
        .clk (clk),
        .rst (rst),
        .d   (1'b1),
        .q   (valid_q)
    );

    assign bus.alu_result_out   = q_bundle.alu_result;
    assign bus.rs2_data_out     = q_bundle.rs2_data;
    assign bus.rd_out           = q_bundle.rd;
    assign bus.reg_write_out    = q_bundle.reg_write;
    assign bus.mem_write_out    = q_bundle.mem_write;
    assign bus.mem_read_out     = q_bundle.mem_read;
    assign bus.branch_taken_out = q_bundle.branch_taken;
    assign bus.valid_out        = valid_q;

    // Read+write together is passed through as-is; both count as access.
    assign bus.mem_access_out = q_bundle.mem_read | q_bundle.mem_write;
    // Writes to x0 are never forwarded.
    assign bus.fwd_en_out     = q_bundle.reg_write & (q_bundle.rd != '0);

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed table-driven bench for ex_mem_pipe_reg.
module tb_ex_mem_pipe_reg;
    import ex_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_mem_pipe_reg_if #(.XLEN(32), .REG_AW(5)) bus ();

    ex_mem_pipe_reg #(.XLEN(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        ex_mem_bundle_t in;
        ex_mem_bundle_t exp;
        logic           ev;
        logic           ea;
        logic           ef;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad   = 0;

    ex_mem_bundle_t prev_exp;
    logic           prev_ev, prev_ea, prev_ef;

    function automatic ex_mem_bundle_t bnd(logic [31:0] a, logic [31:0] s,
                                           logic [4:0] rd, logic rw, logic mw,
                                           logic mr, logic bt);
        ex_mem_bundle_t r;
        r.alu_result   = a;
        r.rs2_data     = s;
        r.rd           = rd;
        r.reg_write    = rw;
        r.mem_write    = mw;
        r.mem_read     = mr;
        r.branch_taken = bt;
        return r;
    endfunction

    function automatic vec_t mk(logic r, ex_mem_bundle_t i, ex_mem_bundle_t e,
                                logic ev, logic ea, logic ef);
        vec_t v;
        v.rst = r; v.in = i; v.exp = e; v.ev = ev; v.ea = ea; v.ef = ef;
        return v;
    endfunction

    function automatic ex_mem_bundle_t observed();
        return bnd(bus.alu_result_out, bus.rs2_data_out, bus.rd_out,
                   bus.reg_write_out, bus.mem_write_out, bus.mem_read_out,
                   bus.branch_taken_out);
    endfunction

    task automatic drive(input logic r, input ex_mem_bundle_t x);
        rst                 = r;
        bus.alu_result_in   = x.alu_result;
        bus.rs2_data_in     = x.rs2_data;
        bus.rd_in           = x.rd;
        bus.reg_write_in    = x.reg_write;
        bus.mem_write_in    = x.mem_write;
        bus.mem_read_in     = x.mem_read;
        bus.branch_taken_in = x.branch_taken;
    endtask

    task automatic check(input string name, input ex_mem_bundle_t e,
                         input logic ev, input logic ea, input logic ef);
        ex_mem_bundle_t got;
        got = observed();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s bundle: got %h want %h", name, got, e);
        end
        total++;
        if (bus.valid_out !== ev) begin
            bad++;
            $display("FAIL %s valid_out: got %b want %b", name, bus.valid_out, ev);
        end
        total++;
        if (bus.mem_access_out !== ea) begin
            bad++;
            $display("FAIL %s mem_access_out: got %b want %b", name, bus.mem_access_out, ea);
        end
        total++;
        if (bus.fwd_en_out !== ef) begin
            bad++;
            $display("FAIL %s fwd_en_out: got %b want %b", name, bus.fwd_en_out, ef);
        end
    endtask

    vec_t vecs[11];

    initial begin
        ex_mem_bundle_t z, s1, s2, s3, s4, s5, s6, s7;
        z  = bnd(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        s1 = bnd(32'hAAAA_BBBB, 32'h1111_2222, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0);
        s2 = bnd(32'hCCCC_DDDD, 32'h3333_4444, 5'd7,  1'b0, 1'b1, 1'b0, 1'b1);
        s3 = bnd(32'h0000_0001, 32'h0000_0000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        s4 = bnd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1);
        s5 = bnd(32'h8000_0000, 32'h0000_0001, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0);
        s6 = bnd(32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0);
        s7 = bnd(32'h5A5A_A5A5, 32'h0F0F_F0F0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1);

        //             rst   in  exp  valid acc fwd
        vecs[0]  = mk(1'b1, z,  z,  1'b0, 1'b0, 1'b0); // held in reset
        vecs[1]  = mk(1'b0, s1, s1, 1'b1, 1'b1, 1'b1); // first capture
        vecs[2]  = mk(1'b0, s2, s2, 1'b1, 1'b1, 1'b0); // rw=0 -> no fwd
        vecs[3]  = mk(1'b1, s2, z,  1'b0, 1'b0, 1'b0); // mid-stream reset
        vecs[4]  = mk(1'b0, s2, s2, 1'b1, 1'b1, 1'b0); // recapture after release
        vecs[5]  = mk(1'b0, s3, s3, 1'b1, 1'b0, 1'b0); // rd=0 with rw=1
        vecs[6]  = mk(1'b0, s4, s4, 1'b1, 1'b1, 1'b1); // all ones, mr&mw kept
        vecs[7]  = mk(1'b0, z,  z,  1'b1, 1'b0, 1'b0); // zero data, still valid
        vecs[8]  = mk(1'b1, s7, z,  1'b0, 1'b0, 1'b0); // reset beats capture
        vecs[9]  = mk(1'b0, s5, s5, 1'b1, 1'b0, 1'b1); // rd=1 forwards
        vecs[10] = mk(1'b0, s6, s6, 1'b1, 1'b1, 1'b0); // load only

        drive(1'b1, z);
        prev_exp = z; prev_ev = 1'b0; prev_ea = 1'b0; prev_ef = 1'b0;

        // Each vector is driven on the falling edge (10, 20, 30 ... ns);
        // outputs must not move until the following rising edge.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].in);
            #1;
            check($sformatf("hold%0d", i), prev_exp, prev_ev, prev_ea, prev_ef);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].ev, vecs[i].ea, vecs[i].ef);
            prev_exp = vecs[i].exp; prev_ev = vecs[i].ev;
            prev_ea = vecs[i].ea; prev_ef = vecs[i].ef;
        end

        // Mid-cycle toggling: two input changes inside one cycle, only the
        // last one present at the edge is captured.
        #2;
        drive(1'b0, s4);
        #1;
        check("mid_toggle_a", s6, 1'b1, 1'b1, 1'b0);
        #2;
        drive(1'b0, s7);
        @(posedge clk);
        #1;
        check("mid_toggle_cap", s7, 1'b1, 1'b1, 1'b1);

        // Reset raised between edges leaves outputs alone until the edge.
        #2;
        rst = 1'b1;
        #1;
        check("rst_between_edges", s7, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("rst_edge_clears", z, 1'b0, 1'b0, 1'b0);

        // First edge after release captures the inputs present then.
        #2;
        drive(1'b0, s1);
        @(posedge clk);
        #1;
        check("release_capture", s1, 1'b1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #5000;
        $display("FAIL timeout: bench did not complete within 5000 ns");
        $fatal(1, "timeout");
    end

endmodule
